// File: rtl/accu_split_if.sv
// accu_split handshake bundle: total input side and beat stream output side.
// slave is the splitter's view, master is the upstream/sink view.
interface accu_split_if;
  logic [9:0] data_in;
  logic       valid_in;
  logic       ready_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       last_out;
  logic       sat_out;

  modport slave (
    input  data_in,
    input  valid_in,
    output ready_in,
    output data_out,
    output valid_out,
    output last_out,
    output sat_out
  );

  modport master (
    output data_in,
    output valid_in,
    input  ready_in,
    input  data_out,
    input  valid_out,
    input  last_out,
    input  sat_out
  );
endinterface

// File: rtl/accu_split.sv
// accu_split: splits a 10-bit total into four 8-bit beats whose sum
// equals the (clamped) total, feeding the accu accumulator.
module accu_split (
  input  logic         clk,
  input  logic         rst_n,
  accu_split_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  typedef struct packed {
    logic [7:0] q;
    logic [1:0] r;
  } grp_t;

  state_t     state;
  logic [1:0] cnt;
  grp_t       grp;

  logic       accept;
  logic       fin;
  logic       step;
  logic       sat_n;
  logic [9:0] tc;
  grp_t       grp_n;
  logic [1:0] cnt_n;

  function automatic logic [7:0] beat(
    input logic [7:0] q,
    input logic [1:0] r,
    input logic [1:0] k
  );
    return q + {7'd0, (k < r)};
  endfunction

  assign bus.ready_in = rst_n &&
    ((state == IDLE) || (cnt == 2'd3));

  assign accept = bus.valid_in && bus.ready_in;
  assign fin    = !accept && (state == SEND)
                  && (cnt == 2'd3);
  assign step   = !accept && (state == SEND)
                  && (cnt != 2'd3);
  assign cnt_n  = cnt + 2'd1;

  // 1020 is the largest total whose even split fits 8-bit beats
  assign sat_n   = bus.data_in > 10'd1020;
  assign tc      = sat_n ? 10'd1020 : bus.data_in;
  assign grp_n.q = tc[9:2];
  assign grp_n.r = tc[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= 2'd0;
      grp           <= '0;
      bus.data_out  <= 8'd0;
      bus.valid_out <= 1'b0;
      bus.last_out  <= 1'b0;
      bus.sat_out   <= 1'b0;
    end else begin
      unique case (1'b1)
        accept: begin
          state         <= SEND;
          cnt           <= 2'd0;
          grp           <= grp_n;
          bus.data_out  <= beat(grp_n.q, grp_n.r, 2'd0);
          bus.valid_out <= 1'b1;
          bus.last_out  <= 1'b0;
          bus.sat_out   <= sat_n;
        end
        fin: begin
          state         <= IDLE;
          cnt           <= 2'd0;
          bus.valid_out <= 1'b0;
          bus.last_out  <= 1'b0;
          bus.sat_out   <= 1'b0;
        end
        step: begin
          cnt           <= cnt_n;
          bus.data_out  <= beat(grp.q, grp.r, cnt_n);
          bus.last_out  <= (cnt_n == 2'd3);
        end
        default: begin
          cnt <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_accu_split.sv
// Directed bench for accu_split: beat values, flags, handshake,
// reset abort and a beat-sum model of the downstream accumulator.
module tb_accu_split;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   acc;

  accu_split_if bus ();

  accu_split dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(
    input string tag,
    input int    obs,
    input int    exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_beat(
    input string tag,
    input int    d,
    input int    l,
    input int    s,
    input int    rdy
  );
    chk({tag, ".data"}, int'(bus.data_out), d);
    chk({tag, ".valid"}, int'(bus.valid_out), 1);
    chk({tag, ".last"}, int'(bus.last_out), l);
    chk({tag, ".sat"}, int'(bus.sat_out), s);
    chk({tag, ".ready"}, int'(bus.ready_in), rdy);
    acc += int'(bus.data_out);
  endtask

  task automatic chk_idle(input string tag, input int d);
    chk({tag, ".valid"}, int'(bus.valid_out), 0);
    chk({tag, ".last"}, int'(bus.last_out), 0);
    chk({tag, ".sat"}, int'(bus.sat_out), 0);
    chk({tag, ".hold"}, int'(bus.data_out), d);
    chk({tag, ".ready"}, int'(bus.ready_in), 1);
  endtask

  task automatic group(
    input string tag,
    input int    t,
    input int    b0,
    input int    b1,
    input int    b2,
    input int    b3,
    input int    s,
    input int    sum
  );
    bus.data_in  = 10'(t);
    bus.valid_in = 1'b1;
    chk({tag, ".rdy0"}, int'(bus.ready_in), 1);
    acc = 0;
    tick();
    bus.valid_in = 1'b0;
    bus.data_in  = 10'd999;
    chk_beat({tag, ".b0"}, b0, 0, s, 0);
    tick();
    chk_beat({tag, ".b1"}, b1, 0, s, 0);
    tick();
    chk_beat({tag, ".b2"}, b2, 0, s, 0);
    tick();
    chk_beat({tag, ".b3"}, b3, 1, s, 1);
    tick();
    chk_idle({tag, ".end"}, b3);
    chk({tag, ".sum"}, acc, sum);
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    acc          = 0;
    rst_n        = 1'b0;
    bus.data_in  = 10'd0;
    bus.valid_in = 1'b1;
    #1;
    chk("rst.data", int'(bus.data_out), 0);
    chk("rst.valid", int'(bus.valid_out), 0);
    chk("rst.last", int'(bus.last_out), 0);
    chk("rst.sat", int'(bus.sat_out), 0);
    chk("rst.ready", int'(bus.ready_in), 0);
    #11;
    bus.valid_in = 1'b0;
    rst_n        = 1'b1;
    tick();
    chk("post_rst.valid", int'(bus.valid_out), 0);
    chk("post_rst.ready", int'(bus.ready_in), 1);

    group("t20", 20, 5, 5, 5, 5, 0, 20);
    group("t114", 114, 29, 29, 28, 28, 0, 114);
    group("t68", 68, 17, 17, 17, 17, 0, 68);
    group("t1023", 1023, 255, 255, 255, 255, 1, 1020);
    group("t1020", 1020, 255, 255, 255, 255, 0, 1020);
    group("t1", 1, 1, 0, 0, 0, 0, 1);

    // back-to-back: 3 then 6 with valid_in held high
    bus.data_in  = 10'd3;
    bus.valid_in = 1'b1;
    chk("b2b.rdy0", int'(bus.ready_in), 1);
    tick();
    bus.data_in = 10'd6;
    chk_beat("b2b.a0", 1, 0, 0, 0);
    tick();
    chk_beat("b2b.a1", 1, 0, 0, 0);
    tick();
    chk_beat("b2b.a2", 1, 0, 0, 0);
    tick();
    chk_beat("b2b.a3", 0, 1, 0, 1);
    tick();
    bus.valid_in = 1'b0;
    chk_beat("b2b.b0", 2, 0, 0, 0);
    tick();
    chk_beat("b2b.b1", 2, 0, 0, 0);
    tick();
    chk_beat("b2b.b2", 1, 0, 0, 0);
    tick();
    chk_beat("b2b.b3", 1, 1, 0, 1);
    tick();
    chk_idle("b2b.end", 1);

    // valid_in while busy is ignored; reset aborts the group
    bus.data_in  = 10'd40;
    bus.valid_in = 1'b1;
    tick();
    bus.data_in = 10'd500;
    chk_beat("rm.b0", 10, 0, 0, 0);
    tick();
    bus.valid_in = 1'b0;
    chk_beat("rm.b1", 10, 0, 0, 0);
    #2;
    rst_n        = 1'b0;
    bus.valid_in = 1'b1;
    #1;
    chk("rm.data", int'(bus.data_out), 0);
    chk("rm.valid", int'(bus.valid_out), 0);
    chk("rm.last", int'(bus.last_out), 0);
    chk("rm.sat", int'(bus.sat_out), 0);
    chk("rm.ready", int'(bus.ready_in), 0);
    tick();
    chk("rm.valid_hold", int'(bus.valid_out), 0);
    chk("rm.ready_hold", int'(bus.ready_in), 0);
    bus.valid_in = 1'b0;
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rm.quiet.valid", int'(bus.valid_out), 0);
      chk("rm.quiet.data", int'(bus.data_out), 0);
      chk("rm.quiet.ready", int'(bus.ready_in), 1);
    end

    group("t114b", 114, 29, 29, 28, 28, 0, 114);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
